sparse_encoder: RTL and testbench

Streaming dense-to-sparse encoder that produces the compressed feature format the PE consumes. It takes one dense IMAGE_SIZE x IMAGE_SIZE frame of pixels in row-major order. For every nonzero pixel it emits one (value, col, row) triple, and at end of frame it reports the nonzero count (feacture_valid_num). It sits between a layer's output and the next PE's feature buffer, with backpressure on both sides.

---
 rtl/sparse_pkg.sv | 22 ++
 rtl/sparse_fifo2.sv | 61 ++++++
 rtl/sparse_encoder.sv | 120 ++++++++++++
 tb/tb_sparse_encoder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_pkg.sv
// Shared types for the dense-to-sparse feature path: frame geometry,
// encoder FSM states and the (value, col, row) triple consumed by the PE.
package sparse_pkg;

   localparam int WORD_LENGTH = 8;
   localparam int IMAGE_SIZE  = 28;
   localparam int COUNT_WIDTH = 16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic [WORD_LENGTH-1:0] value;
      logic [WORD_LENGTH-1:0] col;
      logic [WORD_LENGTH-1:0] row;
   } triple_t;

endpackage

// File: rtl/sparse_fifo2.sv
// Two-entry registered FIFO of triples with valid/ready on both sides.
// Entry 0 is always the head, so the output comes straight from a register.
module sparse_fifo2
   import sparse_pkg::*;
(
   input  logic       clk,
   input  logic       i_flush,
   input  logic       i_push_valid,
   output logic       o_push_ready,
   input  triple_t    i_push_data,
   output logic       o_pop_valid,
   input  logic       i_pop_ready,
   output triple_t    o_pop_data,
   output logic [1:0] o_count
);

   triple_t    r_head;
   triple_t    r_tail;
   logic [1:0] r_count;
   logic       w_push;
   logic       w_pop;

   assign o_push_ready = (r_count < 2'd2);
   assign o_pop_valid  = (r_count != 2'd0);
   assign o_pop_data   = r_head;
   assign o_count      = r_count;

   assign w_push = i_push_valid && o_push_ready;
   assign w_pop  = o_pop_valid && i_pop_ready;

   // Head/tail shift register; a simultaneous push and pop keeps the count
   always_ff @(posedge clk) begin
      if (i_flush) begin
         r_count <= 2'd0;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) r_head <= i_push_data;
               else                 r_tail <= i_push_data;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_head  <= r_tail;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_head <= i_push_data;
               end else begin
                  r_head <= r_tail;
                  r_tail <= i_push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/sparse_encoder.sv
// Streaming dense-to-sparse encoder: scans one row-major frame, emits a
// (value, col, row) triple per nonzero pixel and reports the nonzero count.
module sparse_encoder #(
   parameter int WORD_LENGTH = sparse_pkg::WORD_LENGTH,
   parameter int IMAGE_SIZE  = sparse_pkg::IMAGE_SIZE,
   parameter int COUNT_WIDTH = sparse_pkg::COUNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WORD_LENGTH-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WORD_LENGTH-1:0] out_value,
   output logic [WORD_LENGTH-1:0] out_col,
   output logic [WORD_LENGTH-1:0] out_row,
   output logic                   done,
   output logic [COUNT_WIDTH-1:0] valid_num
);

   import sparse_pkg::*;

   localparam logic [WORD_LENGTH-1:0] LAST_IDX = WORD_LENGTH'(IMAGE_SIZE - 1);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [WORD_LENGTH-1:0] r_col;
   logic [WORD_LENGTH-1:0] r_row;
   logic [COUNT_WIDTH-1:0] r_nnz;
   logic [COUNT_WIDTH-1:0] r_valid_num;

   logic                   w_accept;
   logic                   w_nonzero;
   logic                   w_last_pix;
   logic                   w_fifo_push_ready;
   logic                   w_fifo_pop_valid;
   logic                   w_pop;
   logic [1:0]             w_fifo_count;
   logic                   w_drained;
   triple_t                w_push_data;
   triple_t                w_head;

   assign in_ready   = (r_state == S_SCAN) && w_fifo_push_ready;
   assign w_accept   = in_valid && in_ready;
   assign w_nonzero  = (in_data != '0);
   assign w_last_pix = (r_row == LAST_IDX) && (r_col == LAST_IDX);
   assign w_pop      = w_fifo_pop_valid && out_ready;
   // FIFO will be empty after this edge, so DONE follows the final pop directly
   assign w_drained  = (w_fifo_count == 2'd0) || ((w_fifo_count == 2'd1) && w_pop);

   always_comb begin
      w_push_data       = '0;
      w_push_data.value = in_data;
      w_push_data.col   = r_col;
      w_push_data.row   = r_row;
   end

   sparse_fifo2 u_fifo (
      .clk          (clk),
      .i_flush      (rst),
      .i_push_valid (w_accept && w_nonzero),
      .o_push_ready (w_fifo_push_ready),
      .i_push_data  (w_push_data),
      .o_pop_valid  (w_fifo_pop_valid),
      .i_pop_ready  (out_ready),
      .o_pop_data   (w_head),
      .o_count      (w_fifo_count)
   );

   assign out_valid = w_fifo_pop_valid;
   assign out_value = w_head.value;
   assign out_col   = w_head.col;
   assign out_row   = w_head.row;
   assign done      = (r_state == S_DONE);
   assign valid_num = r_valid_num;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_SCAN;
         S_SCAN:  if (w_accept && w_last_pix) w_state_nxt = S_FLUSH;
         S_FLUSH: if (w_drained) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Scan position and nonzero count; valid_num latches on entry to DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col       <= '0;
         r_row       <= '0;
         r_nnz       <= '0;
         r_valid_num <= '0;
      end else begin
         if ((r_state == S_IDLE) && start) begin
            r_col <= '0;
            r_row <= '0;
            r_nnz <= '0;
         end else if (w_accept) begin
            if (r_col == LAST_IDX) begin
               r_col <= '0;
               r_row <= r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
            if (w_nonzero) r_nnz <= r_nnz + 1'b1;
         end
         if ((r_state == S_FLUSH) && (w_state_nxt == S_DONE)) r_valid_num <= r_nnz;
      end
   end

endmodule

// File: tb/tb_sparse_encoder.sv
// Randomized bench for sparse_encoder: a frame-level reference model turns each
// dense frame into the expected ordered triple list, count and done timing.
module tb_sparse_encoder;

   localparam int W    = 8;
   localparam int N    = 28;
   localparam int NPIX = N * N;
   localparam int CW   = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_value;
   logic [W-1:0]  out_col;
   logic [W-1:0]  out_row;
   logic          done;
   logic [CW-1:0] valid_num;

   always #5 clk = ~clk;

   sparse_encoder dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_value (out_value),
      .out_col   (out_col),
      .out_row   (out_row),
      .done      (done),
      .valid_num (valid_num)
   );

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic [7:0]  pix [NPIX];
   logic [23:0] exp_q [$];
   int          exp_nnz = 0;
   int          n_pop = 0;
   int          n_done = 0;
   int          done_cyc = 0;
   int          last_pop_cyc = 0;
   int          last_acc_cyc = 0;
   int          first_acc_cyc = 0;
   logic        prev_stall = 1'b0;
   logic [23:0] prev_trip = '0;
   logic [23:0] last_trip = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Output-side monitor: ordering, hold stability, done pulse and count
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check_eq("hold_valid", out_valid, 1);
            if (out_valid) check_eq("hold_stable", {out_value, out_col, out_row}, prev_trip);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check_eq("pop_queue_empty", exp_q.size(), 1);
            else check_eq($sformatf("triple%0d", n_pop), {out_value, out_col, out_row}, exp_q.pop_front());
            last_trip    = {out_value, out_col, out_row};
            n_pop++;
            last_pop_cyc = cyc;
         end
         prev_stall = out_valid && !out_ready;
         prev_trip  = {out_value, out_col, out_row};
         if (done) begin
            n_done++;
            done_cyc = cyc;
            check_eq("valid_num_at_done", valid_num, exp_nnz);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_out_ready(input int mode, input int stall_left);
      if (mode == 1) out_ready = ($urandom_range(0, 99) < 60);
      else           out_ready = (stall_left == 0);
   endtask

   // or_mode: 0 always ready, 1 random, 2 stall 10 cycles after first accept
   task automatic run_frame(input string name, input int gap_pct, input int or_mode,
                            input int abort_at, input bit glitch);
      int k = 0;
      int guard = 0;
      int stall_left = 0;
      int bp_acc = 0;
      int exp_done;
      exp_q.delete();
      exp_nnz = 0;
      for (int i = 0; i < NPIX; i++) begin
         if (pix[i] != 0) begin
            exp_q.push_back({pix[i], 8'(i % N), 8'(i / N)});
            exp_nnz++;
         end
      end
      n_pop = 0;
      n_done = 0;
      last_pop_cyc = 0;
      first_acc_cyc = 0;
      start = 1'b1;
      in_valid = 1'b0;
      drive_out_ready(or_mode, 0);
      tick();
      start = 1'b0;
      while (k < NPIX && guard < 20000) begin
         in_valid = ($urandom_range(0, 99) >= gap_pct);
         in_data  = pix[k];
         start    = glitch && (k == 100);
         drive_out_ready(or_mode, stall_left);
         @(negedge clk);
         if (or_mode == 2 && stall_left == 1) check_eq({name, "_bp_in_ready_low"}, in_ready, 0);
         if (in_valid && in_ready) begin
            if (k == 0) begin
               first_acc_cyc = cyc;
               if (or_mode == 2) stall_left = 11;
            end else if (!out_ready) begin
               bp_acc++;
            end
            last_acc_cyc = cyc;
            k++;
         end
         if (stall_left > 0) stall_left--;
         guard++;
         tick();
         if (abort_at > 0 && k == abort_at) begin
            rst = 1'b1;
            in_valid = 1'b0;
            start = 1'b0;
            exp_q.delete();
            tick();
            rst = 1'b0;
            repeat (3) tick();
            @(negedge clk);
            check_eq({name, "_no_done"}, n_done, 0);
            check_eq({name, "_out_valid"}, out_valid, 0);
            check_eq({name, "_in_ready"}, in_ready, 0);
            check_eq({name, "_valid_num"}, valid_num, 0);
            tick();
            return;
         end
      end
      check_eq({name, "_all_accepted"}, k, NPIX);
      in_valid = 1'b0;
      in_data  = '0;
      start    = glitch;
      drive_out_ready(or_mode, 0);
      tick();
      start = 1'b0;
      guard = 0;
      while (n_done == 0 && guard < 3000) begin
         drive_out_ready(or_mode, 0);
         tick();
         guard++;
      end
      check_eq({name, "_done_seen"}, n_done, 1);
      exp_done = last_acc_cyc + 2;
      if (n_pop > 0 && last_pop_cyc + 1 > exp_done) exp_done = last_pop_cyc + 1;
      check_eq({name, "_done_cycle"}, done_cyc, exp_done);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check_eq({name, "_idle_in_ready"}, in_ready, 0);
      check_eq({name, "_done_once"}, n_done, 1);
      check_eq({name, "_pop_count"}, n_pop, exp_nnz);
      check_eq({name, "_leftover"}, exp_q.size(), 0);
      check_eq({name, "_valid_num_held"}, valid_num, exp_nnz);
      if (or_mode == 2) check_eq({name, "_bp_accepts"}, bp_acc, 1);
      if (gap_pct == 0 && or_mode == 0) check_eq({name, "_throughput"}, last_acc_cyc - first_acc_cyc, NPIX - 1);
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check_eq("rst_in_ready", in_ready, 0);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_value", out_value, 0);
      check_eq("rst_out_col", out_col, 0);
      check_eq("rst_out_row", out_row, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_valid_num", valid_num, 0);
      tick();
      rst = 1'b0;
      in_valid = 1'b1;
      in_data = 8'h55;
      tick();
      @(negedge clk);
      check_eq("idle_ignores_in_valid", in_ready, 0);
      tick();

      for (int i = 0; i < NPIX; i++) pix[i] = 8'h00;
      run_frame("zero", 0, 0, -1, 1'b0);

      pix[3 * N + 5] = 8'h7F;
      run_frame("single", 20, 0, -1, 1'b0);

      for (int i = 0; i < NPIX; i++) pix[i] = 8'((i % 255) + 1);
      run_frame("dense", 0, 0, -1, 1'b0);
      check_eq("dense_last_triple", last_trip, {8'(((NPIX - 1) % 255) + 1), 8'(N - 1), 8'(N - 1)});

      run_frame("bp", 0, 2, -1, 1'b0);

      for (int i = 0; i < NPIX; i++)
         pix[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame("rand", 30, 1, -1, 1'b0);

      for (int i = 0; i < NPIX; i++)
         pix[i] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame("abort", 10, 1, 400, 1'b0);

      for (int i = 0; i < NPIX; i++) pix[i] = 8'h00;
      pix[0] = 8'($urandom_range(1, 255));
      for (int i = 1; i < 5; i++) pix[i * 190 + $urandom_range(1, 100)] = 8'($urandom_range(1, 255));
      run_frame("after_abort", 0, 0, -1, 1'b0);

      for (int i = 0; i < NPIX; i++)
         pix[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame("glitch", 10, 1, -1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
